// File: rtl/shake_absorb_loader.sv
// Packs host message words into rate-sized blocks, appends SHAKE padding (0x1F ... 0x80), hands blocks to permute.
// Latency: last word accepted in cycle N -> block_valid in N+1 (full block) or N+2 (padded final block).
// Backpressure: data_ready is low outside LOAD; a block in HOLD keeps block_out/last_block frozen until block_ready.
// Ports: start/operation_mode_in/input_size_in open a message; data_in/data_valid/data_ready carry message words;
//        block_out/block_valid/block_ready/last_block present blocks; busy spans start .. final block handoff.
// Build option SHAKE_LOADER_BLOCK_COUNT_EN adds blocks_sent[15:0] (handoff counter) and size_error (unaligned size).
module shake_absorb_loader #(
    parameter int         W                 = 64,
    parameter int         RATE_MAX          = 1344,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b01,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          operation_mode_in,
    input  logic [31:0]         input_size_in,
    input  logic [W-1:0]        data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [RATE_MAX-1:0] block_out,
    output logic                block_valid,
    input  logic                block_ready,
    output logic                last_block,
    output logic                busy
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
    ,
    output logic [15:0]         blocks_sent,
    output logic                size_error
`endif
);

    localparam int WB     = W / 8;
    localparam int RB128  = RATE_MAX / 8;
    localparam int RB256  = 1088 / 8;
    localparam int NWORDS = RATE_MAX / W;
    localparam int IDXW   = $clog2(NWORDS + 1);
    localparam int POSW   = $clog2(RB128 + 1);
    localparam int WBW    = $clog2(WB + 1);
    localparam int REMW   = 29;

    localparam logic [IDXW-1:0] DEPTH128 = IDXW'(RATE_MAX / W);
    localparam logic [IDXW-1:0] DEPTH256 = IDXW'(1088 / W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            mode128_q, mode128_d;
    logic [REMW-1:0] rem_q, rem_d;      // remaining message bytes
    logic [IDXW-1:0] idx_q, idx_d;      // next word slot in the block
    logic [POSW-1:0] pos_q, pos_d;      // message bytes already in the block
    logic            last_q, last_d;
    logic [7:0]      blk_q [RB128];     // block bytes in message order
    logic [7:0]      blk_d [RB128];

`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    // Without the size check the sub-byte size bits are simply dropped.
    logic            unused_size_lsbs;
    assign unused_size_lsbs = ^input_size_in[2:0];
`endif

    logic [IDXW-1:0] depth;
    logic [POSW-1:0] rate_bytes;
    logic [WBW-1:0]  word_bytes;
    logic [REMW-1:0] rem_after;
    logic [POSW-1:0] pos_after;
    logic            mode_ok;

    always_comb begin
        depth      = mode128_q ? DEPTH128 : DEPTH256;
        rate_bytes = mode128_q ? POSW'(RB128) : POSW'(RB256);
        // A partial final word contributes only its remaining upper bytes.
        word_bytes = (rem_q >= REMW'(WB)) ? WBW'(WB) : WBW'(rem_q);
        rem_after  = rem_q - REMW'(word_bytes);
        pos_after  = pos_q + POSW'(word_bytes);
        mode_ok    = (operation_mode_in == SHAKE128_MODE_VEC) ||
                     (operation_mode_in == SHAKE256_MODE_VEC);
    end

    logic [POSW-1:0] wr_idx;
    logic [7:0]      pad_byte;

    always_comb begin
        state_d   = state_q;
        mode128_d = mode128_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        last_d    = last_q;
        blk_d     = blk_q;
        wr_idx    = '0;
        pad_byte  = 8'h00;
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && mode_ok) begin
                    mode128_d = (operation_mode_in == SHAKE128_MODE_VEC);
                    rem_d     = input_size_in[31:3];
                    idx_d     = '0;
                    pos_d     = '0;
                    last_d    = 1'b0;
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
                    cnt_d     = '0;
                    err_d     = |input_size_in[2:0];
                    state_d   = (|input_size_in[2:0]) ? S_IDLE : S_LOAD;
`else
                    state_d   = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (rem_q == '0) begin
                    // Empty message, or the previous block ended exactly on the message end.
                    state_d = S_PAD;
                end else if (data_valid) begin
                    for (int b = 0; b < WB; b++) begin
                        wr_idx = pos_q + POSW'(b);
                        if (wr_idx < POSW'(RB128)) begin
                            blk_d[wr_idx] = (b < int'(word_bytes)) ? data_in[W-1-8*b -: 8] : 8'h00;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    pos_d = pos_after;
                    rem_d = rem_after;
                    if (rem_after == '0 && pos_after < rate_bytes) begin
                        state_d = S_PAD;
                    end else if (idx_q == depth - 1'b1) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_PAD: begin
                for (int p = 0; p < RB128; p++) begin
                    pad_byte = (POSW'(p) < pos_q) ? blk_q[p] : 8'h00;
                    if (POSW'(p) == pos_q) begin
                        pad_byte = 8'h1F;
                    end
                    if (POSW'(p) == rate_bytes - POSW'(1)) begin
                        pad_byte = pad_byte | 8'h80;
                    end
                    blk_d[p] = pad_byte;
                end
                last_d  = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (block_ready) begin
                    blk_d   = '{default: 8'h00};
                    idx_d   = '0;
                    pos_d   = '0;
                    last_d  = 1'b0;
                    state_d = last_q ? S_IDLE : S_LOAD;
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode128_q <= 1'b0;
            rem_q     <= '0;
            idx_q     <= '0;
            pos_q     <= '0;
            last_q    <= 1'b0;
            blk_q     <= '{default: 8'h00};
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode128_q <= mode128_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            last_q    <= last_d;
            blk_q     <= blk_d;
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign data_ready  = (state_q == S_LOAD) && (rem_q != '0);
    assign block_valid = (state_q == S_HOLD);
    assign last_block  = last_q;
    assign busy        = (state_q != S_IDLE);

`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
    assign blocks_sent = cnt_q;
    assign size_error  = err_q;
`endif

    // Word i occupies the top-down slot i; inside it the first message byte is the least significant byte.
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
        for (genvar gb = 0; gb < WB; gb++) begin : g_byte
            assign block_out[RATE_MAX - W - gi*W + gb*8 +: 8] = blk_q[gi*WB + gb];
        end
    end

endmodule

// File: tb/tb_shake_absorb_loader.sv
module tb_shake_absorb_loader;
    localparam int W        = 64;
    localparam int RATE_MAX = 1344;
    localparam logic [1:0] M128 = 2'b01;
    localparam logic [1:0] M256 = 2'b10;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [1:0]          operation_mode_in;
    logic [31:0]         input_size_in;
    logic [W-1:0]        data_in;
    logic                data_valid;
    logic                data_ready;
    logic [RATE_MAX-1:0] block_out;
    logic                block_valid;
    logic                block_ready;
    logic                last_block;
    logic                busy;
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
    logic [15:0]         blocks_sent;
    logic                size_error;
`endif

    shake_absorb_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .operation_mode_in (operation_mode_in),
        .input_size_in     (input_size_in),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .block_out         (block_out),
        .block_valid       (block_valid),
        .block_ready       (block_ready),
        .last_block        (last_block),
        .busy              (busy)
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
        ,
        .blocks_sent       (blocks_sent),
        .size_error        (size_error)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int blocks_seen = 0;
    bit auto_ready = 1'b1;

    logic [RATE_MAX-1:0] exp_blk_q [$];
    bit                  exp_last_q [$];
    logic [RATE_MAX-1:0] cap_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [RATE_MAX-1:0] act, input logic [RATE_MAX-1:0] exp);
        int fw;
        fw = -1;
        n_assert++;
        if (act !== exp) begin
            for (int i = 0; i < RATE_MAX/64; i++)
                if (fw < 0 && act[RATE_MAX-1-i*64 -: 64] !== exp[RATE_MAX-1-i*64 -: 64]) fw = i;
            if (fw < 0) fw = 0;
            n_fail++;
            $display("FAIL %s: word %0d got %h required %h", name, fw,
                     act[RATE_MAX-1-fw*64 -: 64], exp[RATE_MAX-1-fw*64 -: 64]);
        end
    endtask

    // Deterministic message content; seed 0 yields bytes 01,02,03,...
    function automatic logic [7:0] msg_byte(input int i, input int seed);
        if (seed == 0) return 8'(i + 1);
        return 8'((i * 7 + seed) & 255);
    endfunction

    // Reference: pad the whole message as one byte string (M || 0x1F || 0.. || 0x80), then cut it
    // into rate-sized blocks laid out as lanes with the first byte least significant.
    task automatic build_exp(input bit is128, input int L, input int seed);
        logic [7:0] P [0:1023];
        logic [RATE_MAX-1:0] blk;
        int r, nb;
        r  = is128 ? 168 : 136;
        nb = L / r + 1;
        for (int i = 0; i < nb * r; i++) P[i] = (i < L) ? msg_byte(i, seed) : 8'h00;
        P[L]        = P[L] ^ 8'h1F;
        P[nb*r - 1] = P[nb*r - 1] | 8'h80;
        for (int k = 0; k < nb; k++) begin
            blk = '0;
            for (int p = 0; p < r; p++)
                blk[RATE_MAX - 64 - (p/8)*64 + (p%8)*8 +: 8] = P[k*r + p];
            exp_blk_q.push_back(blk);
            exp_last_q.push_back(k == nb - 1);
        end
    endtask

    initial begin
        block_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            block_ready = auto_ready;
        end
    end

    // Compare process: every cycle a block is presented it must match the model's head block.
    always @(negedge clk) begin
        if (rst === 1'b1 && block_valid === 1'b1) begin
            if (exp_blk_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_block: block_valid=1 required 0");
            end else begin
                chk_blk("block_out", block_out, exp_blk_q[0]);
                chk("last_block", 64'(last_block), 64'(exp_last_q[0]));
                chk("data_ready_in_hold", 64'(data_ready), 64'd0);
                if (block_ready === 1'b1) begin
                    cap_q.push_back(block_out);
                    void'(exp_blk_q.pop_front());
                    void'(exp_last_q.pop_front());
                    blocks_seen++;
                end
            end
        end
    end

    task automatic start_msg(input logic [1:0] mode, input int size_bits);
        @(posedge clk);
        #1;
        operation_mode_in = mode;
        input_size_in     = 32'(size_bits);
        start             = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feeds nw words; bytes beyond the message length carry 0xAA filler that the loader must drop.
    task automatic feed_words(input int nw, input int L, input int seed, output bit ok);
        logic [63:0] word;
        int budget;
        ok = 1'b1;
        for (int j = 0; j < nw; j++) begin
            for (int b = 0; b < 8; b++)
                word[63-8*b -: 8] = (8*j + b < L) ? msg_byte(8*j + b, seed) : 8'hAA;
            data_in    = word;
            data_valid = 1'b1;
            budget     = 0;
            forever begin
                @(negedge clk);
                if (data_ready === 1'b1) break;
                budget++;
                if (budget > 300) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL data_ready_timeout: word %0d not accepted", j);
                    data_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_msg(input logic [1:0] mode, input int size_bits, input int seed,
                           input int exp_nblk, input int exp_lat, input string tag);
        int L, nw, base, k;
        bit ok;
        L    = size_bits / 8;
        nw   = (L + 7) / 8;
        base = blocks_seen;
        cap_q.delete();
        build_exp(mode == M128, L, seed);
        start_msg(mode, size_bits);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        feed_words(nw, L, seed, ok);
        if (ok && exp_lat >= 0) begin
            k = 0;
            while (block_valid !== 1'b1 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        end
        wait_idle(tag);
        chk({tag, "_nblocks"}, 64'(blocks_seen - base), 64'(exp_nblk));
        chk({tag, "_model_drained"}, 64'(exp_blk_q.size()), 64'd0);
        exp_blk_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RATE_MAX-1:0] lit;
        logic [RATE_MAX-1:0] snap;
        bit ok;

        rst = 1'b0;
        start = 1'b0;
        operation_mode_in = 2'b00;
        input_size_in = '0;
        data_in = '0;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_ready", 64'(data_ready), 64'd0);
        chk("reset_block_valid", 64'(block_valid), 64'd0);
        chk("reset_last_block", 64'(last_block), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk_blk("reset_block_out", block_out, '0);
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
        chk("reset_blocks_sent", 64'(blocks_sent), 64'd0);
        chk("reset_size_error", 64'(size_error), 64'd0);
`endif
        rst = 1'b1;

        // SHAKE128 empty message: padding-only block.
        run_msg(M128, 0, 1, 1, -1, "s128_empty");
        lit = '0;
        lit[1287:1280] = 8'h1F;
        lit[63:56]     = 8'h80;
        chk("s128_empty_blocks", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() > 0) chk_blk("s128_empty_literal", cap_q[0], lit);

        // SHAKE256, one word 0102030405060708.
        run_msg(M256, 64, 0, 1, 1, "s256_one_word");
        lit = '0;
        lit[1343:1280] = 64'h0807060504030201;
        lit[1223:1216] = 8'h1F;
        lit[319:312]   = 8'h80;
        if (cap_q.size() > 0) chk_blk("s256_one_word_literal", cap_q[0], lit);

        // SHAKE256 exactly one block of data: data block then a padding-only block.
        run_msg(M256, 1088, 5, 2, 0, "s256_boundary");
        lit = '0;
        lit[1287:1280] = 8'h1F;
        lit[319:312]   = 8'h80;
        if (cap_q.size() > 1) chk_blk("s256_boundary_pad_literal", cap_q[1], lit);

        // SHAKE128 167 bytes: pad and final bit share the last byte.
        run_msg(M128, 1336, 3, 1, 1, "s128_coincident");
        if (cap_q.size() > 0) begin
            chk("s128_byte0", 64'(cap_q[0][1287:1280]), 64'h03);
            chk("s128_byte7", 64'(cap_q[0][1343:1336]), 64'h34);
            chk("s128_byte166", 64'(cap_q[0][55:48]), 64'h8D);
            chk("s128_byte167", 64'(cap_q[0][63:56]), 64'h9F);
        end

        run_msg(M256, 1080, 9, 1, 1, "s256_partial_word");
        run_msg(M128, 2688, 11, 3, 0, "s128_two_full");
        run_msg(M256, 3000, 13, 3, 1, "s256_3000");
`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
        chk("blocks_sent_3000", 64'(blocks_sent), 64'd3);
`endif

        // Unsupported modes are ignored.
        start_msg(2'b00, 64);
        chk("bad_mode0_busy", 64'(busy), 64'd0);
        start_msg(2'b11, 64);
        chk("bad_mode3_busy", 64'(busy), 64'd0);
        chk("bad_mode3_ready", 64'(data_ready), 64'd0);

        // Stall in HOLD for 10 cycles; a start pulse meanwhile must be ignored.
        auto_ready = 1'b0;
        @(posedge clk);
        #1;
        cap_q.delete();
        build_exp(1'b0, 16, 21);
        start_msg(M256, 128);
        feed_words(2, 16, 21, ok);
        for (int k = 0; k < 20 && block_valid !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        snap = block_out;
        chk("stall_valid", 64'(block_valid), 64'd1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                operation_mode_in = M128;
                input_size_in = 32'd800;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk_blk("stall_block_stable", block_out, snap);
            chk("stall_data_ready", 64'(data_ready), 64'd0);
            chk("stall_valid_held", 64'(block_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        auto_ready = 1'b1;
        wait_idle("stall");
        chk("stall_model_drained", 64'(exp_blk_q.size()), 64'd0);

        // Reset in the middle of LOAD discards the partial block.
        start_msg(M256, 640);
        feed_words(2, 80, 7, ok);
        chk("midload_ready", 64'(data_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data_ready", 64'(data_ready), 64'd0);
        chk("midrst_block_valid", 64'(block_valid), 64'd0);
        chk("midrst_last_block", 64'(last_block), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk_blk("midrst_block_out", block_out, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_msg(M128, 64, 17, 1, 1, "after_reset");

`ifdef SHAKE_LOADER_BLOCK_COUNT_EN
        start_msg(M256, 12);
        chk("size_error_set", 64'(size_error), 64'd1);
        chk("size_error_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("size_error_stays_idle", 64'(busy), 64'd0);
        run_msg(M256, 64, 0, 1, 1, "after_size_error");
        chk("size_error_cleared", 64'(size_error), 64'd0);
        chk("blocks_sent_one", 64'(blocks_sent), 64'd1);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
